// File: rtl/disp_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : disp_scan_ctrl
// Purpose  : Digit-scan timing and tear-free frame buffer with per-digit blink
//            for a 4-digit multiplexed display.
// Revision : 1.0 - initial release
// ============================================================================
module disp_scan_ctrl #(
  parameter int DIV_MAX      = 50000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] hex_in,
  input  logic [3:0]  point_in,
  input  logic [3:0]  blink_en,
  output logic [15:0] Hexs,
  output logic [1:0]  Scan,
  output logic [3:0]  Point,
  output logic [3:0]  Les,
  output logic        frame_tick,
  output logic        pending
);

  localparam int c_cw = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
  localparam int c_fw = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [c_cw-1:0] c_cnt_last   = c_cw'(DIV_MAX - 1);
  localparam logic [c_fw-1:0] c_frame_last = c_fw'(BLINK_FRAMES - 1);

  logic [c_cw-1:0] r_cnt;
  logic [c_fw-1:0] r_frame_cnt;
  logic            r_blink_phase;
  logic [15:0]     r_sh_hex;
  logic [3:0]      r_sh_point;
  logic [3:0]      r_sh_blink;
  logic [3:0]      r_blink_mask;

  logic            w_slot_end;
  logic            w_boundary;
  logic            w_frame_wrap;
  logic            w_next_phase;
  logic [15:0]     w_next_hex;
  logic [3:0]      w_next_point;
  logic [3:0]      w_next_mask;

  assign w_slot_end   = (r_cnt == c_cnt_last);
  assign w_boundary   = w_slot_end && (Scan == 2'd3);
  assign w_frame_wrap = (r_frame_cnt == c_frame_last);
  assign w_next_phase = w_frame_wrap ? ~r_blink_phase : r_blink_phase;

  // A load coinciding with the boundary bypasses the shadow so it is not
  // delayed by a whole frame.
  always_comb begin
    w_next_hex   = Hexs;
    w_next_point = Point;
    w_next_mask  = r_blink_mask;
    if (load) begin
      w_next_hex   = hex_in;
      w_next_point = point_in;
      w_next_mask  = blink_en;
    end else if (pending) begin
      w_next_hex   = r_sh_hex;
      w_next_point = r_sh_point;
      w_next_mask  = r_sh_blink;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt         <= '0;
      Scan          <= 2'd0;
      Hexs          <= 16'h0000;
      Point         <= 4'h0;
      Les           <= 4'h0;
      r_sh_hex      <= 16'h0000;
      r_sh_point    <= 4'h0;
      r_sh_blink    <= 4'h0;
      r_blink_mask  <= 4'h0;
      pending       <= 1'b0;
      r_frame_cnt   <= '0;
      r_blink_phase <= 1'b0;
      frame_tick    <= 1'b0;
    end else begin
      r_cnt      <= w_slot_end ? '0 : r_cnt + 1'b1;
      frame_tick <= w_boundary;
      if (w_slot_end) begin
        Scan <= Scan + 2'd1;
      end
      if (load) begin
        r_sh_hex   <= hex_in;
        r_sh_point <= point_in;
        r_sh_blink <= blink_en;
      end
      // Every visible output moves only here, so a frame is never torn.
      if (w_boundary) begin
        pending       <= 1'b0;
        Hexs          <= w_next_hex;
        Point         <= w_next_point;
        r_blink_mask  <= w_next_mask;
        r_frame_cnt   <= w_frame_wrap ? '0 : r_frame_cnt + 1'b1;
        r_blink_phase <= w_next_phase;
        Les           <= w_next_mask & {4{w_next_phase}};
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_disp_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_disp_scan_ctrl
// Purpose  : Directed vector table plus randomized run against a cycle-count
//            reference model of disp_scan_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_disp_scan_ctrl;

  localparam int DIV_MAX      = 4;
  localparam int BLINK_FRAMES = 2;
  localparam int FRAME_LEN    = 4 * DIV_MAX;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] hex_in;
  logic [3:0]  point_in;
  logic [3:0]  blink_en;
  logic [15:0] Hexs;
  logic [1:0]  Scan;
  logic [3:0]  Point;
  logic [3:0]  Les;
  logic        frame_tick;
  logic        pending;

  int n_checks = 0;
  int n_fail   = 0;

  disp_scan_ctrl #(
    .DIV_MAX      (DIV_MAX),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .hex_in     (hex_in),
    .point_in   (point_in),
    .blink_en   (blink_en),
    .Hexs       (Hexs),
    .Scan       (Scan),
    .Point      (Point),
    .Les        (Les),
    .frame_tick (frame_tick),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  // Reference model: time since reset and number of completed frames.
  int          m_t;
  int          m_frames;
  logic [15:0] m_sh_hex, m_hex;
  logic [3:0]  m_sh_pt, m_sh_bl, m_pt, m_mask;
  logic        m_pend, m_tick;

  function automatic logic [3:0] m_les();
    return ((m_frames / BLINK_FRAMES) % 2 == 1) ? m_mask : 4'h0;
  endfunction

  function automatic logic [1:0] m_scan();
    return 2'((m_t / DIV_MAX) % 4);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic l, input logic [15:0] h,
                            input logic [3:0] p, input logic [3:0] b);
    logic bnd;
    if (r) begin
      m_t = 0; m_frames = 0;
      m_sh_hex = '0; m_sh_pt = '0; m_sh_bl = '0;
      m_hex = '0; m_pt = '0; m_mask = '0;
      m_pend = 1'b0; m_tick = 1'b0;
    end else begin
      bnd = (m_t % FRAME_LEN) == FRAME_LEN - 1;
      if (l) begin
        m_sh_hex = h; m_sh_pt = p; m_sh_bl = b;
        m_pend = 1'b1;
      end
      m_tick = bnd;
      if (bnd) begin
        if (l) begin
          m_hex = h; m_pt = p; m_mask = b;
        end else if (m_pend) begin
          m_hex = m_sh_hex; m_pt = m_sh_pt; m_mask = m_sh_bl;
        end
        m_pend = 1'b0;
        m_frames++;
      end
      m_t++;
    end
  endtask

  task automatic step(input logic r, input logic l, input logic [15:0] h,
                      input logic [3:0] p, input logic [3:0] b);
    rst = r; load = l; hex_in = h; point_in = p; blink_en = b;
    @(posedge clk);
    model_edge(r, l, h, p, b);
    #1;
    check("cycle_outputs", {4'h0, Hexs, Point, Les, Scan, pending, frame_tick},
          {4'h0, m_hex, m_pt, m_les(), m_scan(), m_pend, m_tick});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b0, 16'($urandom()), 4'($urandom()), 4'($urandom()));
  endtask

  typedef struct {
    int          idle_n;
    logic        rst;
    logic        load;
    logic [15:0] hex;
    logic [3:0]  pt;
    logic [3:0]  bl;
    logic [15:0] e_hex;
    logic [3:0]  e_pt;
    logic [3:0]  e_les;
    logic [1:0]  e_scan;
    logic        e_pend;
    logic        e_tick;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int n, logic r, logic l, logic [15:0] h, logic [3:0] p,
                              logic [3:0] b, logic [15:0] eh, logic [3:0] ep,
                              logic [3:0] el, logic [1:0] es, logic epd, logic et);
    vec_t v;
    v.idle_n = n; v.rst = r; v.load = l; v.hex = h; v.pt = p; v.bl = b;
    v.e_hex = eh; v.e_pt = ep; v.e_les = el; v.e_scan = es; v.e_pend = epd; v.e_tick = et;
    return v;
  endfunction

  initial begin
    rst = 1'b1; load = 1'b0; hex_in = '0; point_in = '0; blink_en = '0;

    // reset with load held high
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 1, 1, 16'hFFFF, 4'hF, 4'hF, 16'h0000, 4'h0, 4'h0, 2'd0, 0, 0));
    // tear-free load at Scan=1
    vecs.push_back(mk(5,  0, 1, 16'h1234, 4'h5, 4'h0, 16'h0000, 4'h0, 4'h0, 2'd1, 1, 0));
    vecs.push_back(mk(8,  0, 0, 16'h0000, 4'h0, 4'h0, 16'h0000, 4'h0, 4'h0, 2'd3, 1, 0));
    vecs.push_back(mk(0,  0, 0, 16'h0000, 4'h0, 4'h0, 16'h1234, 4'h5, 4'h0, 2'd0, 0, 1));
    // overwrite before the boundary
    vecs.push_back(mk(2,  0, 1, 16'hAAAA, 4'h0, 4'h0, 16'h1234, 4'h5, 4'h0, 2'd0, 1, 0));
    vecs.push_back(mk(3,  0, 1, 16'hBBBB, 4'h0, 4'h0, 16'h1234, 4'h5, 4'h0, 2'd1, 1, 0));
    vecs.push_back(mk(7,  0, 0, 16'h0000, 4'h0, 4'h0, 16'h1234, 4'h5, 4'h0, 2'd3, 1, 0));
    vecs.push_back(mk(0,  0, 0, 16'h0000, 4'h0, 4'h0, 16'hBBBB, 4'h0, 4'h0, 2'd0, 0, 1));
    // load exactly on the boundary cycle
    vecs.push_back(mk(15, 0, 1, 16'h5A5A, 4'hF, 4'h0, 16'h5A5A, 4'hF, 4'h0, 2'd0, 0, 1));
    // blink on digit 3
    vecs.push_back(mk(0,  0, 1, 16'h5A5A, 4'hF, 4'h8, 16'h5A5A, 4'hF, 4'h0, 2'd0, 1, 0));
    vecs.push_back(mk(14, 0, 0, 16'h0000, 4'h0, 4'h0, 16'h5A5A, 4'hF, 4'h0, 2'd0, 0, 1));
    vecs.push_back(mk(30, 0, 0, 16'h0000, 4'h0, 4'h0, 16'h5A5A, 4'hF, 4'h0, 2'd3, 0, 0));
    vecs.push_back(mk(0,  0, 0, 16'h0000, 4'h0, 4'h0, 16'h5A5A, 4'hF, 4'h8, 2'd0, 0, 1));
    vecs.push_back(mk(31, 0, 0, 16'h0000, 4'h0, 4'h0, 16'h5A5A, 4'hF, 4'h0, 2'd0, 0, 1));
    vecs.push_back(mk(31, 0, 0, 16'h0000, 4'h0, 4'h0, 16'h5A5A, 4'hF, 4'h8, 2'd0, 0, 1));
    // reset mid-operation discards pending shadow
    vecs.push_back(mk(0,  0, 1, 16'h1234, 4'h5, 4'h0, 16'h5A5A, 4'hF, 4'h8, 2'd0, 1, 0));
    vecs.push_back(mk(14, 0, 0, 16'h0000, 4'h0, 4'h0, 16'h1234, 4'h5, 4'h0, 2'd0, 0, 1));
    vecs.push_back(mk(7,  0, 1, 16'hCCCC, 4'hA, 4'hF, 16'h1234, 4'h5, 4'h0, 2'd2, 1, 0));
    vecs.push_back(mk(0,  1, 1, 16'hFFFF, 4'hF, 4'hF, 16'h0000, 4'h0, 4'h0, 2'd0, 0, 0));
    vecs.push_back(mk(15, 0, 0, 16'h0000, 4'h0, 4'h0, 16'h0000, 4'h0, 4'h0, 2'd0, 0, 1));

    foreach (vecs[i]) begin
      idle(vecs[i].idle_n);
      step(vecs[i].rst, vecs[i].load, vecs[i].hex, vecs[i].pt, vecs[i].bl);
      check($sformatf("vec%0d_hexs", i),    32'(Hexs),       32'(vecs[i].e_hex));
      check($sformatf("vec%0d_point", i),   32'(Point),      32'(vecs[i].e_pt));
      check($sformatf("vec%0d_les", i),     32'(Les),        32'(vecs[i].e_les));
      check($sformatf("vec%0d_scan", i),    32'(Scan),       32'(vecs[i].e_scan));
      check($sformatf("vec%0d_pending", i), 32'(pending),    32'(vecs[i].e_pend));
      check($sformatf("vec%0d_tick", i),    32'(frame_tick), 32'(vecs[i].e_tick));
    end

    // randomized traffic with occasional resets
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 399) == 0, $urandom_range(0, 9) == 0,
           16'($urandom()), 4'($urandom()), 4'($urandom()));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
